// File: rtl/mac_pkg.sv
// Shared definitions for the MAC dot-product sequencer and its arithmetic unit.
package mac_pkg;

  localparam int unsigned FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/mac_unit.sv
// Combinational IEEE-754 single-precision multiply-add: result = a*b + acc.
// Single rounding (round-to-nearest-even); denormal inputs/outputs flush to zero.
module mac_unit
  import mac_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  input  logic [FP_W-1:0] acc,
  output logic [FP_W-1:0] result
);

  localparam int unsigned XW = 51;

  logic               sa, sb, sc, sp, sbig, ssml, sr;
  logic [7:0]         ea, eb, ec;
  logic               za, zb, zc, ia, ib, ic, na, nb, nc;
  logic [23:0]        ma, mb, mc;
  logic [47:0]        prod;
  logic signed [11:0] ep, ecx, emax, dexp, eres;
  logic [XW-1:0]      xp, xc, big, sml, shd, r;
  logic [XW-2:0]      n;
  logic [5:0]         dsh, lead;
  logic [22:0]        frac;
  logic [23:0]        rsum;
  logic               sticky_al, sticky_lo, rbit;

  always_comb begin
    sa = a[31];   ea = a[30:23];
    sb = b[31];   eb = b[30:23];
    sc = acc[31]; ec = acc[30:23];
    za = (ea == 8'd0);
    zb = (eb == 8'd0);
    zc = (ec == 8'd0);
    ia = (ea == 8'hFF) && (a[22:0] == '0);
    ib = (eb == 8'hFF) && (b[22:0] == '0);
    ic = (ec == 8'hFF) && (acc[22:0] == '0);
    na = (ea == 8'hFF) && (a[22:0] != '0);
    nb = (eb == 8'hFF) && (b[22:0] != '0);
    nc = (ec == 8'hFF) && (acc[22:0] != '0);
    ma = za ? '0 : {1'b1, a[22:0]};
    mb = zb ? '0 : {1'b1, b[22:0]};
    mc = zc ? '0 : {1'b1, acc[22:0]};

    sp   = sa ^ sb;
    prod = ma * mb;
    ep   = 12'(ea) + 12'(eb) - 12'sd127;
    ecx  = zc ? ep : 12'(ec);

    // Both operands share one fixed-point frame: bit 48 is the units place.
    xp = {1'b0, prod, 2'b00};
    xc = zc ? '0 : {2'b00, mc, 25'd0};

    if (ep >= ecx) begin
      big = xp; sml = xc; sbig = sp; ssml = sc; emax = ep;  dexp = ep - ecx;
    end else begin
      big = xc; sml = xp; sbig = sc; ssml = sp; emax = ecx; dexp = ecx - ep;
    end

    dsh = dexp[5:0];
    if (dexp > 12'sd50) begin
      shd       = '0;
      sticky_al = (sml != '0);
    end else begin
      shd       = sml >> dsh;
      sticky_al = ((shd << dsh) != sml);
    end
    shd[0] = shd[0] | sticky_al;

    if (sbig == ssml) begin
      r = big + shd; sr = sbig;
    end else if (big >= shd) begin
      r = big - shd; sr = sbig;
    end else begin
      r = shd - big; sr = ssml;
    end

    lead = '0;
    for (int unsigned i = 0; i < XW; i++) begin
      if (r[i]) lead = 6'(i);
    end
    n    = (XW-1)'(r << (6'd50 - lead));
    eres = emax + 12'(lead) - 12'sd48;

    frac      = n[49:27];
    rbit      = n[26];
    sticky_lo = |n[25:0];
    rsum      = {1'b0, frac} + 24'(rbit & (sticky_lo | frac[0]));
    if (rsum[23]) eres = eres + 12'sd1;
    frac = rsum[22:0];

    if (na || nb || nc || (ia && zb) || (ib && za) || ((ia || ib) && ic && (sp != sc)))
      result = 32'h7FC0_0000;
    else if (ia || ib)
      result = {sp, 8'hFF, 23'd0};
    else if (ic)
      result = acc;
    else if (za || zb)
      result = zc ? {sp & sc, 31'd0} : acc;
    else if (r == '0)
      result = FP_ZERO;
    else if (eres >= 12'sd255)
      result = {sr, 8'hFF, 23'd0};
    else if (eres <= 12'sd0)
      result = {sr, 31'd0};
    else
      result = {sr, eres[7:0], frac};
  end

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: streams operand pairs through mac_unit, accumulating
// in beat order, and hands back one result per job over a valid/ready port.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_a,
  input  logic [FP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_result
);

  state_e           state_q;
  logic [FP_W-1:0]  acc_q, acc_d, res_q;
  logic [LEN_W-1:0] cnt_q, len_q;

  mac_unit u_mac (
    .a      (in_a),
    .b      (in_b),
    .acc    (acc_q),
    .result (acc_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= FP_ZERO;
      cnt_q   <= '0;
      len_q   <= '0;
      res_q   <= FP_ZERO;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) begin
              res_q   <= acc_d;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        // Unused encoding 2'd3 falls here and behaves as IDLE.
        default: begin
          if (start) begin
            len_q <= len;
            acc_q <= FP_ZERO;
            cnt_q <= '0;
            if (len == '0) begin
              res_q   <= FP_ZERO;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_ACCUM;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready   = (state_q == ST_ACCUM);
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q == ST_ACCUM) || (state_q == ST_DONE);
  assign out_result = res_q;

endmodule
